data_memory_ext: RTL and testbench

- Parametrised successor to the single-cycle word-only data RAM.
- Byte-addressed, little-endian data memory supporting byte, half and word accesses, with sign or zero extension on loads.
- Valid/ready request and response channels; one-cycle registered read latency; misaligned and out-of-range access detection.
- Sits between the MIPS memory stage (lb/lbu/lh/lhu/lw/sb/sh/sw) and the storage array.

---
 rtl/dmem_pkg.sv | 72 +++++++
 rtl/dmem_byte_ram.sv | 46 ++++
 rtl/data_memory_ext.sv | 144 ++++++++++++++
 tb/tb_data_memory_ext.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for data_memory_ext.
//   size_e        : access size encoding used on req_size
//   rsp_state_e   : response-slot state (EMPTY / FULL)
//   is_bad_align  : misalignment / reserved-size detection
//   byte_enable   : per-byte write enables for a store
//   align_wdata   : replicate right-aligned store data onto every lane
//   load_extract  : lane-select and sign/zero-extend a loaded word
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    // Reserved size is folded in here so one signal covers "bad shape".
    function automatic logic is_bad_align(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: is_bad_align = 1'b0;
            SZ_HALF: is_bad_align = lane[0];
            SZ_WORD: is_bad_align = |lane;
            default: is_bad_align = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: byte_enable = 4'b0001 << lane;
            SZ_HALF: byte_enable = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    endfunction

    // Copying the datum onto every lane lets the byte enables alone pick
    // where it lands, so no shifter is needed on the write path.
    function automatic logic [31:0] align_wdata(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: align_wdata = {4{wd[7:0]}};
            SZ_HALF: align_wdata = {2{wd[15:0]}};
            default: align_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input size_e       sz,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: load_extract = {{24{~uns & b[7]}}, b};
            SZ_HALF: load_extract = {{16{~uns & h[15]}}, h};
            SZ_WORD: load_extract = word;
            default: load_extract = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// -----------------------------------------------------------------------------
// dmem_byte_ram
// DEPTH x 32-bit storage with four byte write enables and a registered read.
// Kept free of control logic so it maps onto FPGA block RAM.
// Optional: DMEM_DEBUG_PORT_EN adds a combinational view of one word.
//   clk      in   clock
//   rd_en    in   capture mem[addr] into rdata on this edge
//   addr     in   word index
//   be       in   per-byte write enables (bit i -> bits [8i+7:8i])
//   wdata    in   lane-replicated write data
//   rdata    out  registered read data, held while rd_en is low
//   dbg_word out  mem[DEBUG_INDEX] (only with DMEM_DEBUG_PORT_EN)
// -----------------------------------------------------------------------------
module dmem_byte_ram #(
    parameter int DEPTH       = 64,
    parameter int IDX_W       = 6,
    parameter int DEBUG_INDEX = 2
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
`ifdef DMEM_DEBUG_PORT_EN
    ,
    output logic [31:0]      dbg_word
`endif
);

    // NOTE: storage arrays get no reset branch; a reset loop over every word
    // prevents block-RAM inference. The zero image is a power-up init only.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (rd_en) rdata <= mem[addr];
    end

`ifdef DMEM_DEBUG_PORT_EN
    assign dbg_word = mem[DEBUG_INDEX];
`endif

endmodule

// File: rtl/data_memory_ext.sv
// -----------------------------------------------------------------------------
// data_memory_ext
// Byte-addressed little-endian data memory for the MIPS memory stage
// (lb/lbu/lh/lhu/lw/sb/sh/sw), valid/ready request and response channels,
// one-cycle registered read latency, misalignment / range fault detection.
// Optional: define DMEM_DEBUG_PORT_EN to add dbg_word = RAM[DEBUG_INDEX].
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  request can be accepted this cycle
//   req_write     in   1 = store, 0 = load
//   req_size      in   size_e encoding
//   req_unsigned  in   loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      in   byte address
//   req_wdata     in   right-aligned store data
//   rsp_valid     out  response present
//   rsp_ready     in   consumer takes the response
//   rsp_rdata     out  extended load data (0 for stores and faults)
//   rsp_err       out  access faulted
//   dbg_word      out  RAM[DEBUG_INDEX] (DMEM_DEBUG_PORT_EN only)
// -----------------------------------------------------------------------------
module data_memory_ext
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int DEBUG_INDEX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_DEBUG_PORT_EN
    ,
    output logic [31:0]       dbg_word
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    size_e       req_sz;
    logic        out_of_range;
    logic        req_fault;
    logic        accept;
    logic        drain;
    logic [3:0]  wr_be;
    logic [31:0] ram_rdata;

    rsp_state_e  state_q, state_d;

    // Captured request attributes needed to shape the response.
    size_e       rsp_size_q;
    logic [1:0]  rsp_lane_q;
    logic        rsp_uns_q;
    logic        rsp_write_q;
    logic        rsp_fault_q;

    assign req_sz       = size_e'(req_size);
    assign out_of_range = req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);
    assign req_fault    = is_bad_align(req_sz, req_addr[1:0]) | out_of_range;

    assign accept = req_valid & req_ready;
    assign drain  = rsp_valid & rsp_ready;

    // Faulting stores must leave the array untouched.
    assign wr_be = (accept & req_write & ~req_fault) ? byte_enable(req_sz, req_addr[1:0])
                                                     : 4'b0000;

    dmem_byte_ram #(
        .DEPTH       (DEPTH),
        .IDX_W       (IDX_W),
        .DEBUG_INDEX (DEBUG_INDEX)
    ) u_ram (
        .clk   (clk),
        .rd_en (accept),
        .addr  (req_addr[IDX_W+1:2]),
        .be    (wr_be),
        .wdata (align_wdata(req_sz, req_wdata)),
        .rdata (ram_rdata)
`ifdef DMEM_DEBUG_PORT_EN
        ,
        .dbg_word (dbg_word)
`endif
    );

    // Response-slot FSM: state register.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Response-slot FSM: next state. FULL with accept but no drain cannot
    // occur because req_ready is low then.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept)          state_d = ST_FULL;
            ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
            default:                        state_d = ST_EMPTY;
        endcase
    end

    // Response-slot FSM: outputs.
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
        req_ready = ~rsp_valid | rsp_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_size_q  <= SZ_BYTE;
            rsp_lane_q  <= 2'b00;
            rsp_uns_q   <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else if (accept) begin
            rsp_size_q  <= req_sz;
            rsp_lane_q  <= req_addr[1:0];
            rsp_uns_q   <= req_unsigned;
            rsp_write_q <= req_write;
            rsp_fault_q <= req_fault;
        end
    end

    // The RAM output register only moves on accept, so these stay stable
    // for as long as the response is stalled.
    assign rsp_err   = rsp_valid & rsp_fault_q;
    assign rsp_rdata = (rsp_valid & ~rsp_fault_q & ~rsp_write_q)
                     ? load_extract(ram_rdata, rsp_size_q, rsp_lane_q, rsp_uns_q)
                     : 32'h0;

endmodule

// File: tb/tb_data_memory_ext.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ext
// Directed bench for data_memory_ext. A byte-array reference model predicts
// each response when a request is accepted; a negedge monitor compares the
// DUT against it every cycle, and the directed sequence adds literal checks.
// -----------------------------------------------------------------------------
module tb_data_memory_ext;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_DEBUG_PORT_EN
    logic [31:0] dbg_word;
`endif

    data_memory_ext #(
        .DEPTH       (DEPTH),
        .ADDR_W      (32),
        .DEBUG_INDEX (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
`ifdef DMEM_DEBUG_PORT_EN
        ,
        .dbg_word     (dbg_word)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic [7:0] mem_b [DEPTH*4];
    rsp_t       exp_q [$];

    function automatic rsp_t predict(input logic wr, input logic [1:0] sz, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wd);
        rsp_t        r;
        int          n;
        logic [31:0] v;
        r.d = 32'h0;
        r.e = 1'b0;
        if (sz == 2'b11) begin
            r.e = 1'b1;
            return r;
        end
        n = 1 << sz;
        if ((addr % n) != 0 || addr >= 32'(DEPTH * 4)) begin
            r.e = 1'b1;
            return r;
        end
        if (wr) begin
            for (int k = 0; k < n; k++) mem_b[addr + k] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(mem_b[addr + k]) << (8 * k));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            r.d = v;
        end
        return r;
    endfunction

    // Per-cycle compare; predicts the accept/drain of the coming edge.
    always @(negedge clk) begin : monitor
        logic ev;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            ev = (exp_q.size() != 0);
            check("mon_rsp_valid", 32'(rsp_valid), 32'(ev));
            check("mon_req_ready", 32'(req_ready), 32'(!ev || rsp_ready));
            if (ev) begin
                check("mon_rsp_rdata", rsp_rdata, exp_q[0].d);
                check("mon_rsp_err", 32'(rsp_err), 32'(exp_q[0].e));
                if (rsp_ready) void'(exp_q.pop_front());
            end
            if (req_valid && (!ev || rsp_ready))
                exp_q.push_back(predict(req_write, req_size, req_unsigned, req_addr, req_wdata));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // One request with rsp_ready high; checks the response one cycle later.
    task automatic xact(input string name, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        int budget;
        budget = 0;
        @(posedge clk); #1;
        set_req(wr, sz, uns, addr, wd);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        while (!req_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check({name, "_accept_wait"}, 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({name, "_valid"}, 32'(rsp_valid), 32'h1);
        check({name, "_rdata"}, rsp_rdata, exp_d);
        check({name, "_err"}, 32'(rsp_err), 32'(exp_e));
    endtask

    // Back-to-back table: lw 0x0, sw 0x10, lw 0x10 (same word next cycle),
    // lb 0xB, lbu 0x8.
    logic        b2b_wr  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  b2b_sz  [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic        b2b_uns [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] b2b_ad  [5] = '{32'h0, 32'h10, 32'h10, 32'hB, 32'h8};
    logic [31:0] b2b_wd  [5] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
    logic [31:0] b2b_exp [5] = '{32'h0, 32'h0, 32'hCAFE_F00D, 32'hFFFF_FF80, 32'h0000_00EF};

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'h1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Word store / load.
        xact("sw_8",   1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("lw_8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);
        // Byte store, signed / unsigned byte loads, word view.
        xact("sb_9",   1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0080, 32'h0, 1'b0);
        xact("lb_9",   1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'hFFFF_FF80, 1'b0);
        xact("lbu_9",  1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'h0000_0080, 1'b0);
        xact("lw_8b",  1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_80EF, 1'b0);
        // Half store / loads and misalignment.
        xact("sh_a",   1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_8001, 32'h0, 1'b0);
        xact("lh_a",   1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'hFFFF_8001, 1'b0);
        xact("lhu_a",  1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h0000_8001, 1'b0);
        xact("lh_b",   1'b0, 2'b01, 1'b0, 32'hB, 32'h0, 32'h0, 1'b1);
        xact("sh_b",   1'b1, 2'b01, 1'b0, 32'hB, 32'h0000_1234, 32'h0, 1'b1);
        xact("lw_2",   1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
        xact("lw_8c",  1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h8001_80EF, 1'b0);
        // Out of range and reserved size.
        xact("sw_oor", 1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h1234_5678, 32'h0, 1'b1);
        xact("lw_oor", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        xact("rsvd_w", 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xact("rsvd_r", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            xact("readback", 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0,
                 (i == 2) ? 32'h8001_80EF : 32'h0, 1'b0);

        // Backpressure: stall the response for three cycles.
        @(posedge clk); #1;
        set_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(b2b_wr[0], b2b_sz[0], b2b_uns[0], b2b_ad[0], b2b_wd[0]);
        for (int i = 0; i < 3; i++) begin
            check("stall_req_ready", 32'(req_ready), 32'h0);
            check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
            check("stall_rsp_rdata", rsp_rdata, 32'h8001_80EF);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            check("b2b_valid", 32'(rsp_valid), 32'h1);
            check("b2b_rdata", rsp_rdata, b2b_exp[j]);
            if (j < 4) set_req(b2b_wr[j+1], b2b_sz[j+1], b2b_uns[j+1], b2b_ad[j+1], b2b_wd[j+1]);
            else       req_valid = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_drained", 32'(rsp_valid), 32'h0);

        // Reset while a store response is pending.
        set_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h1122_3344);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_pre_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_valid", 32'(rsp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        xact("lw_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h1122_3344, 1'b0);

`ifdef DMEM_DEBUG_PORT_EN
        check("dbg_before", dbg_word, 32'h8001_80EF);
        xact("sw_dbg", 1'b1, 2'b10, 1'b0, 32'h8, 32'h5A5A_A5A5, 32'h0, 1'b0);
        check("dbg_after", dbg_word, 32'h5A5A_A5A5);
`endif

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
